// File: rtl/aes_ct_byte_serializer.sv
// Buffers AES ciphertext blocks in a DEPTH-entry FIFO and streams each block MSB byte first.
// Optional macro AES_SER_DROP_CNT_EN builds the saturating dropped-block counter on drop_cnt.
module aes_ct_byte_serializer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [127:0]     in_block,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   input  logic             tx_ready,
   output logic [CNT_W-1:0] fifo_count,
   output logic             busy,
   output logic             overflow,
   output logic [7:0]       drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q;
   logic [127:0]       shreg_q;
   logic [3:0]         byte_cnt_q;
   logic               tx_valid_q;
   logic               busy_q;
   logic               overflow_q;

   logic [127:0]       mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               last_acc;
   logic               pop;
   logic               full;
   logic               push;
   logic               drop;

   // A pop on the final byte frees a slot in the same cycle, so a full FIFO can still accept.
   assign last_acc = (state_q == SEND) && tx_ready && (byte_cnt_q == 4'd15);
   assign pop      = (count_q != '0) && ((state_q == IDLE) || last_acc);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign push     = in_valid && (!full || pop);
   assign drop     = in_valid && full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= drop;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_block;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         byte_cnt_q <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  shreg_q    <= mem_q[rd_ptr_q];
                  byte_cnt_q <= '0;
                  state_q    <= SEND;
                  tx_valid_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            SEND: begin
               if (tx_ready) begin
                  if (pop) begin
                     shreg_q    <= mem_q[rd_ptr_q];
                     byte_cnt_q <= '0;
                  end else begin
                     shreg_q    <= {shreg_q[119:0], 8'h00};
                     byte_cnt_q <= byte_cnt_q + 4'd1;
                     if (byte_cnt_q == 4'd15) begin
                        state_q    <= IDLE;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_q    <= IDLE;
               tx_valid_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

`ifdef AES_SER_DROP_CNT_EN
   logic [7:0] drop_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = '0;
`endif

   assign tx_valid   = tx_valid_q;
   assign tx_data    = shreg_q[127:120];
   assign busy       = busy_q;
   assign overflow   = overflow_q;
   assign fifo_count = count_q;

endmodule
